// File: rtl/kyber_pkg.sv
// kyber_pkg -- constants and FSM encodings shared by the Kyber datapath blocks.
//   KYBER_Q       : Kyber modulus
//   KYBER_N       : coefficients per polynomial
//   COEFF_W       : width of a coefficient word in RAM
//   ctrl_state_e  : controller FSM state encoding
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEFF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/mod_addsub_q.sv
// mod_addsub_q -- combinational modular add/subtract for coefficients in [0, Q-1].
// Ports:
//   sub_i  : 0 = a + b mod Q, 1 = a - b mod Q
//   a_i    : coefficient A (bits [15:12] ignored)
//   b_i    : coefficient B (bits [15:12] ignored)
//   y_o    : reduced result, upper nibble always zero
module mod_addsub_q
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic                 sub_i,
  input  logic [COEFF_W-1:0]   a_i,
  input  logic [COEFF_W-1:0]   b_i,
  output logic [COEFF_W-1:0]   y_o
);

  logic [12:0] q13;
  logic [12:0] a13;
  logic [12:0] b13;
  logic [12:0] addend;
  logic [13:0] sum;
  logic [13:0] red;
  logic        unused_bits;

  assign q13 = 13'(Q);
  assign a13 = {1'b0, a_i[11:0]};
  assign b13 = {1'b0, b_i[11:0]};

  // Subtraction is folded into an addition of (Q - B) so a single
  // conditional subtract of Q reduces both operations; B = 0 gives A + Q -> A.
  assign addend = sub_i ? (q13 - b13) : b13;
  assign sum    = {1'b0, a13} + {1'b0, addend};
  assign red    = (sum >= {1'b0, q13}) ? (sum - {1'b0, q13}) : sum;

  assign y_o = {4'b0000, red[11:0]};

  assign unused_bits = ^{a_i[15:12], b_i[15:12], red[13:12]};

endmodule

// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl -- streams two coefficient RAMs through a mod-Q add/subtract
// into a result RAM, one coefficient per cycle.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op_sub     : one-cycle request in IDLE; op_sub selects A-B (1) or A+B (0)
//   abort             : cancels an operation in RUN/DRAIN, squashing pending writes
//   busy, done        : busy in RUN/DRAIN; done pulses once on normal completion
//   rd_en, rd_addr    : shared read strobe/address to the A and B RAMs
//   a_data, b_data    : RAM read data, valid the cycle after rd_en
//   wr_en, wr_addr, wr_data : result RAM write port
module poly_add_ctrl
  import kyber_pkg::*;
#(
  parameter int N_COEFF = KYBER_N,
  parameter int ADDR_W  = 8,
  parameter int Q       = KYBER_Q
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_sub,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [COEFF_W-1:0]  a_data,
  input  logic [COEFF_W-1:0]  b_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [COEFF_W-1:0]  wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFF - 1);

  ctrl_state_e          state_q, state_d;
  logic                 drain_cnt_q;
  logic                 op_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic                 rd_vld_q;     // read data arrives this cycle
  logic [ADDR_W-1:0]    rd_addr_p_q;  // address belonging to the arriving data
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [COEFF_W-1:0]   wr_data_q;
  logic [COEFF_W-1:0]   res;
  logic                 abort_hit;

  // Abort only means something while an operation is in flight.
  assign abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (abort)                        state_d = ST_IDLE;
        else if (rd_addr_q == LAST_ADDR)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Two drain cycles cover the read-data and result-register stages.
        if (abort)            state_d = ST_IDLE;
        else if (drain_cnt_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mod_addsub_q #(.Q(Q)) u_mod (
    .sub_i (op_q),
    .a_i   (a_data),
    .b_i   (b_data),
    .y_o   (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 1'b0;
      op_q        <= 1'b0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_p_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == ST_DRAIN) ? ~drain_cnt_q : 1'b0;

      if ((state_q == ST_IDLE) && start) begin
        op_q      <= op_sub;
        rd_addr_q <= '0;
      end else if ((state_q == ST_RUN) && !abort && (rd_addr_q != LAST_ADDR)) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end

      rd_vld_q <= rd_en && !abort_hit;
      if (rd_en) rd_addr_p_q <= rd_addr_q;

      // Abort kills both pipeline stages so nothing is written afterwards.
      wr_en_q <= rd_vld_q && !abort_hit;
      if (rd_vld_q && !abort_hit) begin
        wr_addr_q <= rd_addr_p_q;
        wr_data_q <= res;
      end
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// tb_poly_add_ctrl -- randomized self-checking bench for poly_add_ctrl.
// Cycle 0 of each operation is the cycle carrying start; every cycle's outputs
// are compared with a schedule derived from the operation timeline.
module tb_poly_add_ctrl;

  localparam int N     = 256;
  localparam int Q     = 3329;
  localparam int MAXC  = 300;
  localparam int NONE  = 100000;
  localparam int B_WR   = 24;
  localparam int B_DONE = 34;
  localparam int B_BUSY = 35;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic        abort;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  logic [35:0] obs   [MAXC];
  logic [35:0] expv  [MAXC];
  logic [35:0] async_snap;

  // model of the held (strobe-low) output values
  logic [7:0]  h_ra;
  logic [7:0]  h_wa;
  logic [15:0] h_wd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poly_add_ctrl #(.N_COEFF(N), .ADDR_W(8), .Q(Q)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_sub  (op_sub),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_data  (a_data),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // coefficient RAMs with one cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  function automatic logic [15:0] ref_val(input bit op, input logic [15:0] a, input logic [15:0] b);
    int av, bv, r;
    av = int'(a[11:0]);
    bv = int'(b[11:0]);
    r  = op ? (av - bv + Q) % Q : (av + bv) % Q;
    return 16'(r);
  endfunction

  function automatic logic [15:0] rnd_coeff();
    logic [3:0]  junk;
    logic [11:0] v;
    junk = 4'($urandom_range(0, 15));
    v    = 12'($urandom_range(0, Q - 1));
    return {junk, v};
  endfunction

  // Drives one operation for ncyc cycles and records observed and expected
  // per-cycle output vectors. abort_c / rst_c / xs1 / xs2 = NONE when unused.
  task automatic run_op(input bit op, input int ncyc, input int abort_c, input int rst_c,
                        input int xs1, input int xs2);
    bit   act;
    logic e_busy, e_done, e_rd, e_wr;
    for (int c = 0; c < ncyc; c++) begin
      start  = (c == 0) || (c == xs1) || (c == xs2);
      op_sub = (c == 0) ? op : 1'($urandom);
      abort  = (c == abort_c);
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1 async_snap = {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data};
      end
      if (c == rst_c + 1) rst_n = 1'b1;
      act    = (c <= abort_c) && (c < rst_c);
      e_busy = act && (c >= 1) && (c <= N + 2);
      e_done = act && (c == N + 3);
      e_rd   = act && (c >= 1) && (c <= N);
      e_wr   = act && (c >= 3) && (c <= N + 2);
      if (e_rd) h_ra = 8'(c - 1);
      if (e_wr) begin
        h_wa = 8'(c - 3);
        h_wd = ref_val(op, mem_a[c-3], mem_b[c-3]);
      end
      if (c >= rst_c) begin
        h_ra = '0;
        h_wa = '0;
        h_wd = '0;
      end
      expv[c] = {e_busy, e_done, e_rd, h_ra, e_wr, h_wa, h_wd};
      @(negedge clk);
      obs[c] = {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data};
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = rnd_coeff();
      mem_b[i] = rnd_coeff();
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b1;
    op_sub = 1'b1;
    abort  = 1'b0;
    h_ra = '0; h_wa = '0; h_wd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data} !== 36'd0) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %h expected 0", c,
                 {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data});
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    $display("reset: outputs held low during reset");
  endtask

  task automatic test_ramp();
    int first_wr, done_cyc, busy_cnt;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 16'(i);
      mem_b[i] = 16'd1;
    end
    run_op(1'b0, N + 6, NONE, NONE, NONE, NONE);
    first_wr = -1; done_cyc = -1; busy_cnt = 0;
    for (int c = 0; c < N + 6; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL ramp cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][B_WR] && first_wr < 0) first_wr = c;
      if (obs[c][B_DONE]) done_cyc = c;
      if (obs[c][B_BUSY]) busy_cnt++;
    end
    n_cmp++;
    if (first_wr !== 3) begin
      n_bad++;
      $display("FAIL ramp_first_wr: got %0d expected 3", first_wr);
    end
    n_cmp++;
    if (done_cyc !== 259) begin
      n_bad++;
      $display("FAIL ramp_done_cyc: got %0d expected 259", done_cyc);
    end
    n_cmp++;
    if (busy_cnt !== 258) begin
      n_bad++;
      $display("FAIL ramp_busy_cnt: got %0d expected 258", busy_cnt);
    end
    $display("ramp add: first_wr=%0d done=%0d busy_cycles=%0d", first_wr, done_cyc, busy_cnt);
  endtask

  task automatic test_edges(input bit op);
    int nbad0;
    nbad0 = n_bad;
    fill_random();
    for (int i = 0; i < N; i += 4) begin
      if (!op) begin
        mem_a[i] = 16'd3328;  mem_b[i] = 16'd3328;
        mem_a[i+1] = 16'd3328; mem_b[i+1] = 16'd1;
        mem_a[i+2] = 16'd1664; mem_b[i+2] = 16'd1665;
      end else begin
        mem_a[i] = 16'd0;  mem_b[i] = 16'd1;
        mem_a[i+1] = 16'd5; mem_b[i+1] = 16'd5;
        mem_a[i+2] = 16'd7; mem_b[i+2] = 16'd0;
      end
    end
    run_op(op, N + 6, NONE, NONE, NONE, NONE);
    for (int c = 0; c < N + 6; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL edges op=%0d cyc %0d: got %h expected %h", op, c, obs[c], expv[c]);
      end
    end
    $display("edges op_sub=%0d: %0d cycle errors", op, n_bad - nbad0);
  endtask

  task automatic test_random();
    bit op;
    for (int k = 0; k < 2; k++) begin
      op = 1'($urandom);
      fill_random();
      run_op(op, N + 6, NONE, NONE, NONE, NONE);
      for (int c = 0; c < N + 6; c++) begin
        n_cmp++;
        if (obs[c] !== expv[c]) begin
          n_bad++;
          if (n_bad <= 20) $display("FAIL random cyc %0d: got %h expected %h", c, obs[c], expv[c]);
        end
      end
      $display("random op_sub=%0d run %0d complete", op, k);
    end
  endtask

  task automatic test_abort();
    int dones;
    fill_random();
    run_op(1'b0, 102, 100, NONE, NONE, NONE);
    dones = 0;
    for (int c = 0; c < 102; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL abort_run cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][B_DONE]) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", dones);
    end
    // restart exactly at cycle 102
    fill_random();
    run_op(1'b1, N + 6, NONE, NONE, NONE, NONE);
    for (int c = 0; c < N + 6; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL abort_restart cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
    // abort during the drain phase
    fill_random();
    run_op(1'b0, N + 6, N + 1, NONE, NONE, NONE);
    for (int c = 0; c < N + 6; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL abort_drain cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
    $display("abort: run abort@100, restart, drain abort@%0d done", N + 1);
  endtask

  task automatic test_ignored_start();
    int nw, nd;
    fill_random();
    run_op(1'($urandom), N + 6, NONE, NONE, 50, N + 3);
    nw = 0; nd = 0;
    for (int c = 0; c < N + 6; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL ign_start cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][B_WR]) nw++;
      if (obs[c][B_DONE]) nd++;
    end
    n_cmp++;
    if (nw !== 256) begin
      n_bad++;
      $display("FAIL ign_start_writes: got %0d expected 256", nw);
    end
    n_cmp++;
    if (nd !== 1) begin
      n_bad++;
      $display("FAIL ign_start_dones: got %0d expected 1", nd);
    end
    $display("ignored starts @50,@%0d: writes=%0d dones=%0d", N + 3, nw, nd);
  endtask

  task automatic test_reset_mid();
    int nw;
    fill_random();
    run_op(1'b0, 125, NONE, 120, NONE, NONE);
    n_cmp++;
    if (async_snap !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h expected 0", async_snap);
    end
    for (int c = 0; c < 125; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL reset_mid cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
    end
    fill_random();
    run_op(1'b1, N + 6, NONE, NONE, NONE, NONE);
    nw = 0;
    for (int c = 0; c < N + 6; c++) begin
      n_cmp++;
      if (obs[c] !== expv[c]) begin
        n_bad++;
        if (n_bad <= 20) $display("FAIL reset_rerun cyc %0d: got %h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][B_WR]) nw++;
    end
    n_cmp++;
    if (nw !== 256) begin
      n_bad++;
      $display("FAIL reset_rerun_writes: got %0d expected 256", nw);
    end
    $display("reset mid-op @120 then rerun: writes=%0d", nw);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    abort  = 1'b0;
    test_reset();
    test_ramp();
    test_edges(1'b0);
    test_edges(1'b1);
    test_random();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
